// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage data-memory access engine:
// funct3 load/store widths, FSM states and common constants.
package mem_access_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] zero_word = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } mau_state_e;

endpackage

// File: rtl/mem_access_unit_format.sv
// Combinational lane formatting: store byte enables and replication,
// load lane extraction with sign/zero extension, and alignment check.
module lsu_format
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] read_word,
  output logic [3:0]  be,
  output logic [31:0] store_word,
  output logic [31:0] load_word,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be         = 4'b1111;
    store_word = store_data;
    misaligned = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be         = 4'b0001 << lane;
        store_word = {4{store_data[7:0]}};
      end
      F3_H, F3_HU: begin
        be         = lane[1] ? 4'b1100 : 4'b0011;
        store_word = {2{store_data[15:0]}};
        misaligned = lane[0];
      end
      F3_W: begin
        misaligned = (lane != 2'b00);
      end
      default: ;
    endcase
  end

  // Unknown funct3 codes fall back to a plain word so nothing is left undefined.
  always_comb begin
    byte_sel  = read_word[{lane, 3'b000} +: 8];
    half_sel  = lane[1] ? read_word[31:16] : read_word[15:0];
    load_word = read_word;
    case (funct3)
      F3_B:    load_word = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_word = {24'h00_0000, byte_sel};
      F3_H:    load_word = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_word = {16'h0000, half_sel};
      default: load_word = read_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: drives a req/gnt/rvalid data bus, stalls the
// pipeline while a transaction is outstanding, and returns extended load data.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        flush_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic [31:0] loaddata_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  mau_state_e state_q, state_d;

  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      lane_q, lane_d;

  logic        req_d, we_d, mis_d, err_d;
  logic [31:0] addr_d, wdata_d, load_d;
  logic [3:0]  be_d;

  logic        access, is_store, to_hit;
  logic [2:0]  fmt_f3;
  logic [1:0]  fmt_lane;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_store, fmt_load;
  logic        fmt_misaligned;

  // A load+store combination is illegal and is resolved as a load.
  assign access   = valid_i & (MemRead_i | MemWrite_i) & ~flush_i;
  assign is_store = MemWrite_i & ~MemRead_i;
  assign to_hit   = (cnt_q == TO_W'(TIMEOUT - 1));

  // While a transaction is in flight the latched width/lane drive the formatter,
  // so load extraction does not depend on the stalled EX/MEM contents.
  assign fmt_f3   = (state_q == IDLE) ? funct3_i    : f3_q;
  assign fmt_lane = (state_q == IDLE) ? addr_i[1:0] : lane_q;

  lsu_format u_format (
    .funct3     (fmt_f3),
    .lane       (fmt_lane),
    .store_data (wdata_i),
    .read_word  (dm_rdata),
    .be         (fmt_be),
    .store_word (fmt_store),
    .load_word  (fmt_load),
    .misaligned (fmt_misaligned)
  );

  assign stall_o = ~rst & (((state_q == IDLE) & access & ~fmt_misaligned) |
                           (state_q == REQ) | (state_q == WAIT_R));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    req_d   = dm_req;
    we_d    = dm_we;
    addr_d  = dm_addr;
    be_d    = dm_be;
    wdata_d = dm_wdata;
    load_d  = loaddata_o;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (fmt_misaligned) begin
            mis_d  = 1'b1;
            load_d = zero_word;
          end else begin
            state_d = REQ;
            cnt_d   = '0;
            f3_d    = funct3_i;
            lane_d  = addr_i[1:0];
            req_d   = 1'b1;
            we_d    = is_store;
            addr_d  = {addr_i[31:2], 2'b00};
            be_d    = fmt_be;
            wdata_d = is_store ? fmt_store : zero_word;
          end
        end
      end
      // An accepted store finishes cleanly even on the last allowed cycle.
      REQ: begin
        cnt_d = cnt_q + TO_W'(1);
        if (dm_gnt && dm_we) begin
          state_d = DONE;
          req_d   = 1'b0;
        end else if (to_hit) begin
          state_d = DONE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          load_d  = zero_word;
        end else if (dm_gnt) begin
          state_d = WAIT_R;
          req_d   = 1'b0;
        end else if (flush_i) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      WAIT_R: begin
        cnt_d = cnt_q + TO_W'(1);
        if (dm_rvalid) begin
          state_d = DONE;
          load_d  = fmt_load;
        end else if (to_hit) begin
          state_d = DONE;
          err_d   = 1'b1;
          load_d  = zero_word;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      f3_q       <= 3'b000;
      lane_q     <= 2'b00;
      dm_req     <= 1'b0;
      dm_we      <= 1'b0;
      dm_addr    <= zero_word;
      dm_be      <= 4'b0000;
      dm_wdata   <= zero_word;
      loaddata_o <= zero_word;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      f3_q       <= f3_d;
      lane_q     <= lane_d;
      dm_req     <= req_d;
      dm_we      <= we_d;
      dm_addr    <= addr_d;
      dm_be      <= be_d;
      dm_wdata   <= wdata_d;
      loaddata_o <= load_d;
      misalign_o <= mis_d;
      bus_err_o  <= err_d;
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access engine of the 5-stage RV32I pipeline, between the EX/MEM register and mem_wb_regs.
- Converts a load/store from EX/MEM into a req/gnt/rvalid transaction on the data-memory bus.
- Generates byte enables and lane-replicated store data, and extracts and sign/zero-extends load data into loaddata_o, which feeds the MEM/WB load-data input.
- Stalls the pipeline while the transaction is outstanding.

Parameters:
- TIMEOUT, 16, maximum cycles spent in REQ+WAIT_R before aborting with bus_err_o.
- TO_W, 5, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_i  in  1  EX/MEM slot holds a real instruction.
- flush_i  in  1  squash current MEM instruction.
- MemRead_i  in  1  instruction is a load.
- MemWrite_i  in  1  instruction is a store.
- funct3_i  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr_i  in  32  effective address (ALU result).
- wdata_i  in  32  rs2 store data.
- dm_req  out  1  bus request.
- dm_we  out  1  1=store.
- dm_addr  out  32  word-aligned address ({addr_i[31:2],2'b00}).
- dm_be  out  4  byte enables.
- dm_wdata  out  32  lane-replicated store data.
- dm_gnt  in  1  request accepted this cycle.
- dm_rvalid  in  1  read data valid.
- dm_rdata  in  32  read word.
- loaddata_o  out  32  extended load result, to mem_wb_regs.
- stall_o  out  1  freeze PC/IF/ID/EX/MEM regs; bubble into MEM/WB.
- misalign_o  out  1  one-cycle misaligned-access pulse.
- bus_err_o  out  1  one-cycle timeout pulse.

Behaviour:
- Reset: async, active-high. While rst=1, all registered outputs are 0, state=IDLE, and stall_o=0.
- access = valid_i & (MemRead_i|MemWrite_i) & ~flush_i. MemRead_i and MemWrite_i both high is illegal; treat the access as a load.
- Misaligned: H/HU with addr_i[0]=1, or W with addr_i[1:0]!=0.

FSM states IDLE, REQ, WAIT_R, DONE:
- IDLE, access and misaligned:
  - misalign_o=1 for one cycle; no request; stall_o=0; loaddata_o<=0.
  - Stay in IDLE.
- IDLE, access and aligned:
  - stall_o=1 combinationally.
  - Next edge: dm_req/dm_we/dm_addr/dm_be/dm_wdata registered; go to REQ; counter cleared.
- REQ: hold all bus outputs stable until dm_gnt.
  - On gnt, a store goes to DONE; a load goes to WAIT_R. dm_req drops on the following edge.
  - flush_i=1 while in REQ, before gnt: drop dm_req and return to IDLE; no DONE, no side effect.
  - Once granted, flush_i is ignored.
- WAIT_R: on dm_rvalid, capture the extended dm_rdata into loaddata_o and go to DONE.
  - rvalid is only sampled in WAIT_R; rvalid coincident with gnt is never produced by the memory.
- DONE: stall_o=0 for exactly one cycle, so the pipeline advances. Unconditionally return to IDLE.
- Minimum latency: store 2 stall cycles; load 3 stall cycles (gnt and rvalid each on the first possible cycle).

Timeout:
- Counter increments every cycle in REQ or WAIT_R.
- When it reaches TIMEOUT: bus_err_o pulses, dm_req<=0, loaddata_o<=0, go to DONE.
- A late rvalid after the timeout is ignored.

stall_o = (IDLE & access & aligned) | REQ | WAIT_R.

Store formatting:
- SB: be = 4'b0001<<addr[1:0]; wdata = {4{wdata_i[7:0]}}.
- SH: be = 4'b0011 if addr[1]=0, else 4'b1100; wdata = {2{wdata_i[15:0]}}.
- SW: be = 4'b1111.

Load formatting:
- Select byte lane addr[1:0] (B/BU) or half lane addr[1] (H/HU).
- Sign-extend for B/H; zero-extend for BU/HU/W.
- Loads also drive dm_be per width.

Other rules:
- loaddata_o holds its value until the next load completes or a misalign/timeout clears it.
- Reset asserted mid-transaction returns to IDLE immediately; the memory is required to drop any pending response on reset.

Decomposition:
- Shared package/define file: funct3 load/store encodings, FSM state encodings, zero_word.
- One natural sub-module, lsu_format: combinational store byte-enable/replication and load extract/extend, instantiated once.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt on the first REQ cycle -> dm_be=1111, dm_wdata=0xDEADBEEF, dm_addr=0x100; stall_o high 2 cycles, then DONE.
- LB addr=0x203, rdata=0x80AABBCC, rvalid 2 cycles after gnt -> loaddata_o=0xFFFFFF80; LBU same -> 0x00000080; stall for the whole wait.
- SH addr=0x12, wdata=0x00001234 -> dm_be=1100, dm_wdata=0x12341234, dm_addr=0x10.
- LW addr=0x102 -> misalign_o single pulse, dm_req never asserted, stall_o=0, loaddata_o=0.
- LH addr=0x40, gnt withheld, flush_i at cycle 2 -> dm_req drops next edge, FSM IDLE, no DONE; second case with gnt held low 16 cycles -> bus_err_o pulse, loaddata_o=0.
- LHU addr=0x22, rdata=0xF00D1234, rst asserted while in WAIT_R -> all outputs 0 immediately; after reset release, a fresh LHU completes with loaddata_o=0x0000F00D.
